// File: rtl/udc_pkg.sv
// udc_pkg: shared FSM state encoding and wrap-count width for the up/down count controller
package udc_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } udc_state_e;
  localparam int UDC_WRAP_W = 8;
endpackage

// File: rtl/udc_step_core.sv
// udc_step_core: mod-N up/down register; ports clk, rst, en (step), up (direction), clr -> q (value), wrap (this step wraps)
module udc_step_core #(
  parameter int N     = 10,
  parameter int WIDTH = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(N - 1);
  logic [WIDTH-1:0] q_q, q_d;
  always_comb begin
    wrap = en && (up ? q_q == MAX : q_q == '0);
    q_d  = clr ? '0 : !en ? q_q : up ? (q_q == MAX ? '0 : q_q + 1'b1) : (q_q == '0 ? MAX : q_q - 1'b1);
  end
  always_ff @(posedge clk) q_q <= rst ? '0 : q_d;
  assign q = q_q;
endmodule

// File: rtl/updown_count_ctrl.sv
// updown_count_ctrl: job controller stepping a mod-N counter toward a target; ports start/dir/target/hold/abort/clr in, count/busy/done/err/steps out, wraps out with UDC_WRAP_COUNT_EN
module updown_count_ctrl import udc_pkg::*; #(
  parameter int N     = 10,
  parameter int WIDTH = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  dir,
  input  logic [WIDTH-1:0]      target,
  input  logic                  hold,
  input  logic                  abort,
  input  logic                  clr,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [WIDTH-1:0]      steps
`ifdef UDC_WRAP_COUNT_EN
  ,
  output logic [UDC_WRAP_W-1:0] wraps
`endif
);
  localparam logic [WIDTH:0] NL = (WIDTH + 1)'(N);
  udc_state_e       state_q, state_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] target_q, target_d, steps_q, steps_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             tgt_ok, accept, at_tgt, step, core_clr;
  always_comb begin
    tgt_ok   = {1'b0, target} < NL;
    accept   = state_q == ST_IDLE && start && tgt_ok;
    at_tgt   = count == target_q;
    step     = state_q == ST_RUN && !abort && !at_tgt && !hold;
    core_clr = state_q == ST_IDLE && clr && !start;
    state_d  = state_q == ST_IDLE ? (accept ? ST_RUN : ST_IDLE)
             : state_q == ST_RUN  ? (abort ? ST_IDLE : at_tgt ? ST_DONE : ST_RUN)
             : ST_IDLE;
    dir_d    = accept ? dir : dir_q;
    target_d = accept ? target : target_q;
    steps_d  = accept ? '0 : step ? steps_q + 1'b1 : steps_q;
    busy_d   = state_d == ST_RUN;
    done_d   = state_d == ST_DONE;
    err_d    = state_q == ST_IDLE && start && !tgt_ok;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      dir_q    <= 1'b0;
      target_q <= '0;
      steps_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      target_q <= target_d;
      steps_q  <= steps_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
`ifdef UDC_WRAP_COUNT_EN
  logic                  wrap;
  logic [UDC_WRAP_W-1:0] wraps_q, wraps_d;
  always_comb wraps_d = accept ? '0 : (wrap && wraps_q != '1) ? wraps_q + 1'b1 : wraps_q;
  always_ff @(posedge clk) wraps_q <= rst ? '0 : wraps_d;
  assign wraps = wraps_q;
  udc_step_core #(.N(N), .WIDTH(WIDTH)) u_core (
    .clk(clk), .rst(rst), .en(step), .up(dir_q), .clr(core_clr), .q(count), .wrap(wrap)
  );
`else
  udc_step_core #(.N(N), .WIDTH(WIDTH)) u_core (
    .clk(clk), .rst(rst), .en(step), .up(dir_q), .clr(core_clr), .q(count), .wrap()
  );
`endif
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign steps = steps_q;
endmodule

// File: tb/tb_updown_count_ctrl.sv
// tb_updown_count_ctrl: directed self-checking bench for updown_count_ctrl with N=10
module tb_updown_count_ctrl;
  logic       clk = 0, rst = 1, start = 0, dir = 0, hold = 0, abort = 0, clr = 0;
  logic [3:0] target = 0;
  logic [3:0] count, steps;
  logic       busy, done, err;
  int         n_checks = 0, n_fail = 0, n;
`ifdef UDC_WRAP_COUNT_EN
  logic [7:0] wraps;
`endif
  updown_count_ctrl #(.N(10), .WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .target(target), .hold(hold),
    .abort(abort), .clr(clr), .count(count), .busy(busy), .done(done), .err(err), .steps(steps)
`ifdef UDC_WRAP_COUNT_EN
    , .wraps(wraps)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done(inout int e);
    while (!done && e < 60) begin
      tick();
      e++;
    end
    check("done_timeout", {31'd0, done}, 1);
  endtask
  task automatic run_job(input logic d, input logic [3:0] t, output int e);
    start = 1; dir = d; target = t;
    tick();
    start = 0;
    e = 1;
    wait_done(e);
    tick();
  endtask
  initial begin
    tick(); tick();
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_steps", steps, 0);
    rst = 0;
    start = 1; dir = 1; target = 3;
    for (int i = 1; i <= 4; i++) begin
      tick();
      start = 0;
      check("up_busy", busy, 1);
      check("up_count", count, i - 1);
    end
    tick();
    check("up_done", done, 1);
    check("up_busy_off", busy, 0);
    check("up_steps", steps, 3);
    check("up_final", count, 3);
    tick();
    check("up_done_pulse", done, 0);
    run_job(0, 1, n);
    check("dn_pre_lat", n, 4);
    check("dn_pre_count", count, 1);
    start = 1; dir = 0; target = 8;
    tick(); start = 0;
    tick(); check("dn_c0", count, 0);
    tick(); check("dn_c9", count, 9);
    tick(); check("dn_c8", count, 8);
    tick();
    check("dn_done", done, 1);
    check("dn_steps", steps, 3);
`ifdef UDC_WRAP_COUNT_EN
    check("dn_wraps", wraps, 1);
`endif
    tick();
    clr = 1; tick(); clr = 0;
    check("clr_a", count, 0);
    start = 1; dir = 1; target = 5;
    tick(); start = 0;
    tick(); tick();
    hold = 1;
    tick(); tick();
    check("hold_count", count, 2);
    check("hold_busy", busy, 1);
    hold = 0;
    n = 5;
    wait_done(n);
    check("hold_lat", n, 9);
    check("hold_steps", steps, 5);
    tick();
    clr = 1; tick(); clr = 0;
    start = 1; dir = 1; target = 7;
    tick(); start = 0;
    tick();
    start = 1; target = 4;
    tick(); start = 0;
    check("ab_ignore_err", err, 0);
    check("ab_count2", count, 2);
    abort = 1;
    tick(); abort = 0;
    check("ab_busy", busy, 0);
    check("ab_count", count, 2);
    check("ab_done", done, 0);
    tick();
    check("ab_done2", done, 0);
    check("ab_hold", count, 2);
    start = 1; target = 12;
    tick(); start = 0;
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    tick();
    check("err_clear", err, 0);
    check("err_count", count, 2);
    start = 1; dir = 1; target = 9;
    tick(); start = 0;
    tick(); tick();
    check("rr_count4", count, 4);
    rst = 1;
    tick(); rst = 0;
    check("rr_count", count, 0);
    check("rr_busy", busy, 0);
    check("rr_done", done, 0);
    check("rr_steps", steps, 0);
    tick();
    check("rr_idle", busy, 0);
    run_job(1, 0, n);
    check("zero_lat", n, 2);
    check("zero_steps", steps, 0);
    run_job(1, 6, n);
    check("six_count", count, 6);
    clr = 1; tick(); clr = 0;
    check("clr_b", count, 0);
    clr = 1; tick(); clr = 0;
    run_job(1, 6, n);
    run_job(1, 1, n);
    check("upwrap_lat", n, 7);
    check("upwrap_count", count, 1);
    check("upwrap_steps", steps, 5);
`ifdef UDC_WRAP_COUNT_EN
    check("upwrap_wraps", wraps, 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
